// File: rtl/alu_pb_pkg.sv
// Shared types for the pushbutton-sequenced add/AND controller.
// Holds the controller state encoding, the button chord codes
// ({left, right}) and the operation select derived from a chord.
package alu_pb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        EXEC  = 2'd2
    } state_e;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_RIGHT = 2'b01;
    localparam logic [1:0] CODE_LEFT  = 2'b10;
    localparam logic [1:0] CODE_BOTH  = 2'b11;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_AND = 1'b1
    } op_e;

    // Left alone selects AND; right alone or both buttons select ADD.
    function automatic op_e code_to_op(input logic [1:0] code);
        return (code == CODE_LEFT) ? OP_AND : OP_ADD;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one button.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   btn_i    - raw asynchronous, bouncy button level
//   stable_o - debounced level (0 out of reset)
// The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles in
// which the synchronized input disagrees with it.
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic stable_o
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any cycle of agreement restarts the count, so bounce shorter than
    // DEBOUNCE_CYCLES can never reach the flip condition.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/alu_pb_controller.sv
// Pushbutton sequencing controller for the 4-bit add/AND lab datapath.
// Debounces left/right buttons, accumulates the chord held while ARMED and,
// once every button is released, performs one operation on A/B.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   left_pushbutton, right_pushbutton  - raw buttons
//   A, B                               - operands (sampled in the EXEC cycle)
//   result, carry, zero                - registered outcome of last operation
//   valid                              - one-cycle pulse when outcome updates
//   busy                               - controller is not IDLE
//   op_count                           - completed operations, wraps at 256
module alu_pb_controller
    import alu_pb_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             left_pushbutton,
    input  logic             right_pushbutton,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             valid,
    output logic             busy,
    output logic [7:0]       op_count
);

    logic       left_stable, right_stable;
    logic [1:0] chord;

    state_e     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic       exec_fire;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             valid_q;
    logic [7:0]       op_count_q, op_count_d;

    logic [WIDTH:0]   sum;

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_i    (left_pushbutton),
        .stable_o (left_stable)
    );

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_i    (right_pushbutton),
        .stable_o (right_stable)
    );

    assign chord = {left_stable, right_stable};
    assign sum   = {1'b0, A} + {1'b0, B};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= CODE_NONE;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            valid_q    <= 1'b0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            valid_q    <= exec_fire;
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        exec_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (chord != CODE_NONE) begin
                    state_d = ARMED;
                    code_d  = chord;
                end
            end
            ARMED: begin
                // Buttons may come and go; the operation is the union of
                // everything held until the last release.
                code_d = code_q | chord;
                if (chord == CODE_NONE) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d   = IDLE;
                exec_fire = (code_q != CODE_NONE);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        op_count_d = op_count_q;
        if (exec_fire) begin
            if (code_to_op(code_q) == OP_AND) begin
                result_d = A & B;
                carry_d  = 1'b0;
            end else begin
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
            end
            zero_d     = (result_d == '0);
            op_count_d = op_count_q + 8'd1;
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign valid    = valid_q;
    assign busy     = (state_q != IDLE);
    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_pb_controller.sv
module tb_alu_pb_controller;

    localparam int W   = 4;
    localparam int DEB = 4;
    localparam logic [15:0] MASK = 16'((1 << DEB) - 1);

    logic         clk;
    logic         rst_n;
    logic         left_pushbutton, right_pushbutton;
    logic [W-1:0] A, B;
    logic [W-1:0] result;
    logic         carry, zero, valid, busy;
    logic [7:0]   op_count;

    int total = 0;
    int bad   = 0;
    int vld_cnt  = 0;
    int busy_cyc = 0;
    bit chk_en   = 0;

    alu_pb_controller #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .left_pushbutton  (left_pushbutton),
        .right_pushbutton (right_pushbutton),
        .A                (A),
        .B                (B),
        .result           (result),
        .carry            (carry),
        .zero             (zero),
        .valid            (valid),
        .busy             (busy),
        .op_count         (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a button's debounced level flips once the last DEB
    // synchronized samples all disagree with it; an operation starts when any
    // debounced button is high, collects the chord, and completes one cycle
    // after every button is released.
    logic [1:0]   m_s1, m_s2, m_stab;
    logic [15:0]  m_h0, m_h1;
    logic         m_active, m_pend, m_valid, m_carry, m_zero;
    logic [1:0]   m_chord;
    logic [W-1:0] m_res;
    logic [7:0]   m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 2'b00; m_s2 <= 2'b00; m_stab <= 2'b00;
            m_h0 <= 16'h0; m_h1 <= 16'h0;
            m_active <= 1'b0; m_pend <= 1'b0; m_valid <= 1'b0;
            m_chord <= 2'b00; m_res <= '0; m_carry <= 1'b0; m_zero <= 1'b0;
            m_cnt <= 8'd0;
        end else begin : upd
            logic [15:0]  h0, h1;
            logic [1:0]   ch;
            logic [W:0]   s;
            logic [W-1:0] r;
            ch = m_stab;
            m_s1 <= {left_pushbutton, right_pushbutton};
            m_s2 <= m_s1;
            h0 = {m_h0[14:0], m_s2[0]};
            h1 = {m_h1[14:0], m_s2[1]};
            m_h0 <= h0;
            m_h1 <= h1;
            if ((h0 & MASK) == (m_stab[0] ? 16'h0 : MASK)) m_stab[0] <= ~m_stab[0];
            if ((h1 & MASK) == (m_stab[1] ? 16'h0 : MASK)) m_stab[1] <= ~m_stab[1];
            if (m_pend) begin
                if (m_chord == 2'b10) begin
                    r = A & B;
                    m_carry <= 1'b0;
                end else begin
                    s = W'(A) + W'(B) + (W+1)'(0);
                    s = {1'b0, A} + {1'b0, B};
                    r = s[W-1:0];
                    m_carry <= s[W];
                end
                m_res   <= r;
                m_zero  <= (r == 0);
                m_valid <= 1'b1;
                m_cnt   <= m_cnt + 8'd1;
                m_pend  <= 1'b0;
                m_active <= 1'b0;
            end else begin
                m_valid <= 1'b0;
                if (!m_active) begin
                    if (ch != 2'b00) begin
                        m_active <= 1'b1;
                        m_chord  <= ch;
                    end
                end else begin
                    m_chord <= m_chord | ch;
                    if (ch == 2'b00) m_pend <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit l, input bit r, input int hold);
        left_pushbutton  = l;
        right_pushbutton = r;
        repeat (hold) step();
        left_pushbutton  = 1'b0;
        right_pushbutton = 1'b0;
        repeat (2 + DEB + 6) step();
    endtask

    task automatic do_rand_op();
        int code;
        int hold;
        code = $urandom_range(1, 3);
        hold = $urandom_range(DEB + 3, DEB + 9);
        left_pushbutton  = code[1];
        right_pushbutton = code[0];
        repeat (hold) begin
            A = W'($urandom); B = W'($urandom);
            step();
        end
        left_pushbutton  = 1'b0;
        right_pushbutton = 1'b0;
        repeat (2 + DEB + 5) begin
            A = W'($urandom); B = W'($urandom);
            step();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_result"},   32'(result),   32'd0);
        chk({tag, "_carry"},    32'(carry),    32'd0);
        chk({tag, "_zero"},     32'(zero),     32'd0);
        chk({tag, "_valid"},    32'(valid),    32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    initial begin
        int v0, b0, n;
        left_pushbutton = 1'b0; right_pushbutton = 1'b0;
        A = '0; B = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        chk_zero_outputs("por");

        fork
            forever begin
                @(negedge clk);
                if (valid === 1'b1) vld_cnt++;
                if (busy === 1'b1) busy_cyc++;
                chk("cyc_result",   32'(result),   32'(m_res));
                chk("cyc_carry",    32'(carry),    32'(m_carry));
                chk("cyc_zero",     32'(zero),     32'(m_zero));
                chk("cyc_valid",    32'(valid),    32'(m_valid));
                chk("cyc_busy",     32'(busy),     32'(m_active | m_pend));
                chk("cyc_op_count", 32'(op_count), 32'(m_cnt));
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Right button alone: ADD 3+5
        A = 4'd3; B = 4'd5;
        v0 = vld_cnt;
        do_op(1'b0, 1'b1, 10);
        chk("add_result",   32'(result),   32'd8);
        chk("add_carry",    32'(carry),    32'd0);
        chk("add_zero",     32'(zero),     32'd0);
        chk("add_op_count", 32'(op_count), 32'd1);
        chk("add_valid_pulses", 32'(vld_cnt - v0), 32'd1);

        // Asynchronous reset in the middle of a clock period
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_rst");
        step();
        rst_n = 1'b1;
        step();

        // Left button alone: AND
        A = 4'b1100; B = 4'b1010;
        do_op(1'b1, 1'b0, 10);
        chk("and_result", 32'(result), 32'b1000);
        chk("and_carry",  32'(carry),  32'd0);
        chk("and_zero",   32'(zero),   32'd0);
        A = 4'd5; B = 4'd10;
        do_op(1'b1, 1'b0, 10);
        chk("and0_result",   32'(result),   32'd0);
        chk("and0_zero",     32'(zero),     32'd1);
        chk("and0_op_count", 32'(op_count), 32'd2);

        // Chord: left, then right joins 3 cycles later -> ADD 9+8
        A = 4'd9; B = 4'd8;
        v0 = vld_cnt;
        left_pushbutton = 1'b1;
        repeat (3) step();
        right_pushbutton = 1'b1;
        repeat (10) step();
        left_pushbutton = 1'b0; right_pushbutton = 1'b0;
        repeat (2 + DEB + 6) step();
        chk("chord_result", 32'(result), 32'd1);
        chk("chord_carry",  32'(carry),  32'd1);
        chk("chord_zero",   32'(zero),   32'd0);
        chk("chord_valid_pulses", 32'(vld_cnt - v0), 32'd1);
        chk("chord_op_count", 32'(op_count), 32'd3);

        // Bounce shorter than the debounce window
        v0 = vld_cnt; b0 = busy_cyc;
        repeat (10) begin
            right_pushbutton = ~right_pushbutton;
            step(); step();
        end
        right_pushbutton = 1'b0;
        repeat (12) step();
        chk("bounce_busy_cycles",  32'(busy_cyc - b0), 32'd0);
        chk("bounce_valid_pulses", 32'(vld_cnt - v0),  32'd0);
        chk("bounce_op_count",     32'(op_count),      32'd3);

        // Reset while ARMED aborts the operation
        right_pushbutton = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("armed_reached", 32'(n < 40), 32'd1);
        #3 rst_n = 1'b0;
        #1 chk_zero_outputs("abort");
        right_pushbutton = 1'b0;
        step();
        rst_n = 1'b1;
        v0 = vld_cnt;
        repeat (15) step();
        chk("abort_valid_pulses", 32'(vld_cnt - v0), 32'd0);
        chk("abort_op_count",     32'(op_count),     32'd0);
        chk("abort_busy",         32'(busy),         32'd0);

        // 256 random operations: op_count wraps back to 0
        v0 = vld_cnt;
        repeat (256) do_rand_op();
        chk("wrap_op_count",     32'(op_count),     32'd0);
        chk("wrap_valid_pulses", 32'(vld_cnt - v0), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
